ps2_scan_decoder: RTL

- Consumes raw PS/2 set-2 scan-code bytes from the PS/2 receiver FIFO through its data/ready/nextdata_n handshake.
- Turns the byte stream into clean key events: code, extended flag, make/break, held status, press counter.
- Sits between the keyboard receiver and the display/LED logic, replacing ad-hoc make/break tracking in the top level.

---
 rtl/ps2_scan_decoder.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_decoder.sv
// PS/2 set-2 scan-code decoder: pops bytes from the receiver FIFO and emits key events.
// Optional ASCII lookup enabled by defining PS2_ASCII_LUT_EN.
module ps2_scan_decoder #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       ps2_data,
    input  logic             ps2_ready,
    input  logic             ps2_overflow,
    output logic             ps2_nextdata_n,
    output logic [7:0]       key_code,
    output logic             key_ext,
    output logic             key_make,
    output logic             key_valid,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic [7:0]       ascii,
    output logic             err
);

    typedef enum logic [1:0] {
        StIdle,
        StAck,
        StDecode
    } state_t;

    state_t     state;
    logic [7:0] byte_r;
    logic       ext;
    logic       brk;
    logic [8:0] held_id;
    logic       ovf_q;

    logic       is_ext_pfx;
    logic       is_brk_pfx;
    logic       is_err_code;
    logic       is_ignored;
    logic       is_key;
    logic [8:0] ev_id;
    logic       id_match;
    logic       ovf_rise;

    always_comb begin
        is_ext_pfx  = (byte_r == 8'hE0);
        is_brk_pfx  = (byte_r == 8'hF0);
        is_err_code = (byte_r == 8'h00) || (byte_r == 8'hFF);
        is_ignored  = (byte_r == 8'hAA) || (byte_r == 8'hFA) || (byte_r == 8'hFE);
        is_key      = !(is_ext_pfx || is_brk_pfx || is_err_code || is_ignored);
        ev_id       = {ext, byte_r};
        id_match    = (held_id == ev_id);
        ovf_rise    = ps2_overflow & ~ovf_q;
    end

    // The byte is classified on the edge leaving ACK so results are visible during DECODE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= StIdle;
            byte_r         <= 8'h00;
            ext            <= 1'b0;
            brk            <= 1'b0;
            held_id        <= 9'h000;
            ovf_q          <= 1'b0;
            ps2_nextdata_n <= 1'b1;
            key_code       <= 8'h00;
            key_ext        <= 1'b0;
            key_make       <= 1'b0;
            key_valid      <= 1'b0;
            key_held       <= 1'b0;
            press_cnt      <= '0;
            err            <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            err       <= 1'b0;
            ovf_q     <= ps2_overflow;

            case (state)
                StIdle: begin
                    if (ps2_ready) begin
                        byte_r         <= ps2_data;
                        ps2_nextdata_n <= 1'b0;
                        state          <= StAck;
                    end
                end

                StAck: begin
                    ps2_nextdata_n <= 1'b1;
                    state          <= StDecode;
                    if (is_ext_pfx) begin
                        ext <= 1'b1;
                    end else if (is_brk_pfx) begin
                        brk <= 1'b1;
                    end else if (is_err_code) begin
                        err <= 1'b1;
                        ext <= 1'b0;
                        brk <= 1'b0;
                    end else if (is_key) begin
                        key_valid <= 1'b1;
                        key_code  <= byte_r;
                        key_ext   <= ext;
                        key_make  <= ~brk;
                        ext       <= 1'b0;
                        brk       <= 1'b0;
                        if (!brk) begin
                            // A typematic repeat of the held key is not a new press.
                            if (!key_held || !id_match) begin
                                key_held  <= 1'b1;
                                held_id   <= ev_id;
                                press_cnt <= press_cnt + CNT_W'(1);
                            end
                        end else if (id_match) begin
                            key_held <= 1'b0;
                        end
                    end
                end

                StDecode: begin
                    state <= StIdle;
                end

                default: begin
                    state          <= StIdle;
                    ps2_nextdata_n <= 1'b1;
                end
            endcase

            // Overflow takes priority over any prefix set by the byte decoded on this edge.
            if (ovf_rise) begin
                err <= 1'b1;
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

`ifdef PS2_ASCII_LUT_EN
    function automatic logic [7:0] set2_to_ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h61;
            8'h32: a = 8'h62;
            8'h21: a = 8'h63;
            8'h23: a = 8'h64;
            8'h24: a = 8'h65;
            8'h2B: a = 8'h66;
            8'h34: a = 8'h67;
            8'h33: a = 8'h68;
            8'h43: a = 8'h69;
            8'h3B: a = 8'h6A;
            8'h42: a = 8'h6B;
            8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;
            8'h31: a = 8'h6E;
            8'h44: a = 8'h6F;
            8'h4D: a = 8'h70;
            8'h15: a = 8'h71;
            8'h2D: a = 8'h72;
            8'h1B: a = 8'h73;
            8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;
            8'h2A: a = 8'h76;
            8'h1D: a = 8'h77;
            8'h22: a = 8'h78;
            8'h35: a = 8'h79;
            8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    logic [7:0] ascii_next;

    always_comb begin
        ascii_next = ext ? 8'h00 : set2_to_ascii(byte_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ascii <= 8'h00;
        end else if (state == StAck && is_key) begin
            ascii <= ascii_next;
        end
    end
`else
    assign ascii = 8'h00;
`endif

endmodule
